// File: rtl/common_types_pkg.sv
// Shared bus and arbiter types for the core memory path.
package common_types_pkg;

    typedef logic [31:0] word_t;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t IACC = 2'd1;
    localparam arb_state_t DACC = 2'd2;
    localparam arb_state_t XACC = 2'd3;

    function automatic logic req_any(input logic ren, input logic [3:0] wen);
        return ren | (|wen);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction, data and dump-master requests onto one RAM port.
// Latency: RAM_LATENCY+1 cycles per access, every access returns through IDLE.
// Backpressure: *wait held high until the requester's access completes.
module mem_arbiter
    import common_types_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       override_ctrl,
    input  logic       iren,
    input  word_t      iaddr,
    output logic       iwait,
    output word_t      iload,
    input  logic       dren,
    input  logic [3:0] dwen,
    input  word_t      daddr,
    input  word_t      dstore,
    output logic       dwait,
    output word_t      dload,
    input  logic       xren,
    input  logic [3:0] xwen,
    input  word_t      xaddr,
    input  word_t      xstore,
    output logic       xwait,
    output word_t      xload,
    output logic       ram_ren,
    output logic [3:0] ram_wen,
    output word_t      ram_addr,
    output word_t      ram_store,
    input  word_t      ram_load
);

    localparam cnt_t LAST = cnt_t'(RAM_LATENCY - 1);

    arb_state_t state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       d_req, x_req, done;

    assign d_req = req_any(dren, dwen);
    assign x_req = req_any(xren, xwen);
    assign done  = (state_q != IDLE) && (cnt_q == LAST);

    // Override only steers the next grant; an access already underway finishes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (override_ctrl && x_req) begin
                state_d = XACC;
            end else if (!override_ctrl && d_req) begin
                state_d = DACC;
            end else if (!override_ctrl && iren) begin
                state_d = IACC;
            end
        end else if (done) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Writes win over a concurrent read request from the same master.
    always_comb begin
        ram_ren   = 1'b0;
        ram_wen   = 4'b0;
        ram_addr  = '0;
        ram_store = '0;
        case (state_q)
            IACC: begin
                ram_ren  = 1'b1;
                ram_addr = iaddr;
            end
            DACC: begin
                ram_addr  = daddr;
                ram_store = dstore;
                if (|dwen) ram_wen = dwen;
                else       ram_ren = 1'b1;
            end
            XACC: begin
                ram_addr  = xaddr;
                ram_store = xstore;
                if (|xwen) ram_wen = xwen;
                else       ram_ren = 1'b1;
            end
            default: ;
        endcase
    end

    assign iwait = iren  && !(done && state_q == IACC);
    assign dwait = d_req && !(done && state_q == DACC);
    assign xwait = x_req && !(done && state_q == XACC);

    assign iload = (done && state_q == IACC) ? ram_load : '0;
    assign dload = (done && state_q == DACC) ? ram_load : '0;
    assign xload = (done && state_q == XACC) ? ram_load : '0;

endmodule
